// File: rtl/core_seq_pkg.sv
// Shared types and constants for the MAC-core tile sequencer:
// FSM states, instruction-word field positions and the idle instruction.
package core_seq_pkg;

    localparam int AW = 11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_FETCH,
        S_W_LOAD,
        S_W_GAP,
        S_X_FETCH,
        S_EXEC,
        S_DRAIN,
        S_FINISH
    } state_t;

    localparam int B_ACC      = 33;
    localparam int B_CEN_P    = 32;
    localparam int B_WEN_P    = 31;
    localparam int B_AP_HI    = 30;
    localparam int B_AP_LO    = 20;
    localparam int B_CEN_X    = 19;
    localparam int B_WEN_X    = 18;
    localparam int B_AX_HI    = 17;
    localparam int B_AX_LO    = 7;
    localparam int B_OFIFO_RD = 6;
    localparam int B_IFIFO_WR = 5;
    localparam int B_IFIFO_RD = 4;
    localparam int B_L0_RD    = 3;
    localparam int B_L0_WR    = 2;
    localparam int B_EXEC     = 1;
    localparam int B_LOAD     = 0;

    // Both SRAMs disabled (active-low CEN/WEN high), every strobe low.
    localparam logic [33:0] IDLE_INST = 34'h1_800C_0000;

endpackage

// File: rtl/core_seq_if.sv
// Job descriptor, drain handshake and instruction/status bundle between
// the job issuer (master) and the sequencer (slave).
interface core_seq_if;
    logic        start;
    logic [10:0] w_base;
    logic [10:0] x_base;
    logic [10:0] p_base;
    logic [10:0] len;
    logic        acc_en;
    logic        ofifo_valid;
    logic [33:0] inst;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output start, w_base, x_base, p_base, len, acc_en, ofifo_valid,
        input  inst, busy, done, err
    );

    modport slave (
        input  start, w_base, x_base, p_base, len, acc_en, ofifo_valid,
        output inst, busy, done, err
    );
endinterface

// File: rtl/core_seq_drain.sv
// OFIFO-to-psum drain: registered ofifo_valid, drained-word count and the
// saturating idle-timeout counter used while waiting in DRAIN.
module core_seq_drain
    import core_seq_pkg::*;
#(
    parameter int DRAIN_TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clr,
    input  logic          i_active,
    input  logic          i_in_drain,
    input  logic          i_ofifo_valid,
    input  logic [AW-1:0] i_len,
    input  logic [AW-1:0] i_p_base,
    output logic          o_rd,
    output logic [AW-1:0] o_addr,
    output logic          o_drained,
    output logic          o_timeout
);
    localparam int TW = $clog2(DRAIN_TIMEOUT + 1);

    logic          r_ov;
    logic [AW-1:0] r_dcnt;
    logic [TW-1:0] r_tcnt;

    assign o_drained = (r_dcnt == i_len);
    assign o_rd      = i_active && r_ov && !o_drained;
    assign o_addr    = i_p_base + r_dcnt;
    assign o_timeout = (r_tcnt == TW'(DRAIN_TIMEOUT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ov   <= 1'b0;
            r_dcnt <= '0;
            r_tcnt <= '0;
        end else begin
            r_ov <= i_ofifo_valid;
            if (i_clr) begin
                r_dcnt <= '0;
                r_tcnt <= '0;
            end else begin
                if (o_rd) r_dcnt <= r_dcnt + AW'(1);
                // Any drained word restarts the idle window; saturate at the limit.
                if (o_rd)
                    r_tcnt <= '0;
                else if (i_in_drain && !o_timeout)
                    r_tcnt <= r_tcnt + TW'(1);
            end
        end
    end
endmodule

// File: rtl/core_seq.sv
// Tile sequencer: turns one job descriptor into the registered 34-bit
// instruction stream for the 8x8 MAC core, draining OFIFO concurrently.
module core_seq
    import core_seq_pkg::*;
#(
    parameter int ROW           = 8,
    parameter int COL           = 8,
    parameter int L0_DEPTH      = 64,
    parameter int LOAD_GAP      = 2 * COL,
    parameter int DRAIN_TIMEOUT = 255
) (
    input logic       clk,
    input logic       reset,
    core_seq_if.slave bus
);
    localparam int CNT_W = 8;

    state_t        r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next, r_chunk, w_chunk_next, w_chunk_calc;
    logic [AW-1:0] r_rem, w_rem_next, r_xi, w_xi_next;
    logic [AW-1:0] r_w_base, r_x_base, r_p_base, r_len;
    logic          r_acc, r_pend, r_busy, r_done, r_err;
    logic [33:0]   r_inst, w_inst_next;
    logic          w_accept, w_timeout_fin;
    logic          w_drain_rd, w_drained, w_timeout;
    logic [AW-1:0] w_paddr;

    assign w_accept     = (r_state == S_IDLE) && bus.start;
    assign w_chunk_calc = (r_rem > AW'(L0_DEPTH)) ? CNT_W'(L0_DEPTH) : CNT_W'(r_rem);

    core_seq_drain #(.DRAIN_TIMEOUT(DRAIN_TIMEOUT)) u_drain (
        .clk          (clk),
        .reset        (reset),
        .i_clr        (w_accept),
        .i_active     (r_state != S_IDLE),
        .i_in_drain   (r_state == S_DRAIN),
        .i_ofifo_valid(bus.ofifo_valid),
        .i_len        (r_len),
        .i_p_base     (r_p_base),
        .o_rd         (w_drain_rd),
        .o_addr       (w_paddr),
        .o_drained    (w_drained),
        .o_timeout    (w_timeout)
    );

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_chunk_next  = r_chunk;
        w_rem_next    = r_rem;
        w_xi_next     = r_xi;
        w_timeout_fin = 1'b0;
        w_inst_next   = IDLE_INST;
        w_inst_next[B_ACC]      = (r_state != S_IDLE) ? r_acc : 1'b0;
        w_inst_next[B_WEN_X]    = 1'b1;
        w_inst_next[B_IFIFO_WR] = 1'b0;
        w_inst_next[B_IFIFO_RD] = 1'b0;
        w_inst_next[B_L0_WR]    = r_pend;
        if (w_drain_rd) begin
            w_inst_next[B_OFIFO_RD]          = 1'b1;
            w_inst_next[B_CEN_P]             = 1'b0;
            w_inst_next[B_WEN_P]             = 1'b0;
            w_inst_next[B_AP_HI:B_AP_LO]     = w_paddr;
        end
        case (r_state)
            S_IDLE: if (bus.start) begin
                w_cnt_next   = '0;
                w_xi_next    = '0;
                w_state_next = (bus.len == '0) ? S_FINISH : S_W_FETCH;
            end
            S_W_FETCH: begin
                w_inst_next[B_CEN_X]         = 1'b0;
                w_inst_next[B_AX_HI:B_AX_LO] = r_w_base + AW'(r_cnt);
                w_cnt_next = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(ROW - 1)) begin
                    w_cnt_next   = '0;
                    w_state_next = S_W_LOAD;
                end
            end
            S_W_LOAD: begin
                w_inst_next[B_L0_RD] = 1'b1;
                w_inst_next[B_LOAD]  = 1'b1;
                w_cnt_next = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(ROW - 1)) begin
                    w_cnt_next   = '0;
                    w_state_next = S_W_GAP;
                end
            end
            S_W_GAP: begin
                w_cnt_next = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(LOAD_GAP - 1)) begin
                    w_cnt_next   = '0;
                    w_chunk_next = w_chunk_calc;
                    w_rem_next   = r_rem - AW'(w_chunk_calc);
                    w_state_next = S_X_FETCH;
                end
            end
            S_X_FETCH: begin
                // Activation index runs on across chunks so addresses stay contiguous.
                w_inst_next[B_CEN_X]         = 1'b0;
                w_inst_next[B_AX_HI:B_AX_LO] = r_x_base + r_xi;
                w_xi_next  = r_xi + AW'(1);
                w_cnt_next = r_cnt + CNT_W'(1);
                if (r_cnt + CNT_W'(1) == r_chunk) begin
                    w_cnt_next   = '0;
                    w_state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                w_inst_next[B_L0_RD] = 1'b1;
                w_inst_next[B_EXEC]  = 1'b1;
                w_cnt_next = r_cnt + CNT_W'(1);
                if (r_cnt + CNT_W'(1) == r_chunk) begin
                    w_cnt_next = '0;
                    if (r_rem != '0) begin
                        w_chunk_next = w_chunk_calc;
                        w_rem_next   = r_rem - AW'(w_chunk_calc);
                        w_state_next = S_X_FETCH;
                    end else begin
                        w_state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_drained) begin
                    w_state_next = S_FINISH;
                end else if (w_timeout) begin
                    w_timeout_fin = 1'b1;
                    w_state_next  = S_FINISH;
                end
            end
            S_FINISH: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_chunk  <= '0;
            r_rem    <= '0;
            r_xi     <= '0;
            r_w_base <= '0;
            r_x_base <= '0;
            r_p_base <= '0;
            r_len    <= '0;
            r_acc    <= 1'b0;
            r_pend   <= 1'b0;
            r_inst   <= IDLE_INST;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_chunk <= w_chunk_next;
            r_xi    <= w_xi_next;
            // SRAM read data lands one cycle later, so l0_wr trails each read.
            r_pend  <= (r_state == S_W_FETCH) || (r_state == S_X_FETCH);
            r_inst  <= w_inst_next;
            r_busy  <= (r_state != S_IDLE) && (r_state != S_FINISH);
            r_done  <= (r_state == S_FINISH);
            if (w_accept) begin
                r_w_base <= bus.w_base;
                r_x_base <= bus.x_base;
                r_p_base <= bus.p_base;
                r_len    <= bus.len;
                r_rem    <= bus.len;
                r_acc    <= bus.acc_en;
                r_err    <= 1'b0;
            end else begin
                r_rem <= w_rem_next;
                if (w_timeout_fin) r_err <= 1'b1;
            end
        end
    end

    assign bus.inst = r_inst;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.err  = r_err;
endmodule

// File: doc/core_seq.md
# core_seq

Tile-level sequencer for the 8×8 MAC core. It accepts one job descriptor (weight, activation and psum base addresses, vector count, accumulate flag) and emits the core's 34-bit instruction word every cycle. Each job is sequenced in order: weight fetch into L0, weight load into the array, then chunked activation fetch and execute. OFIFO results are drained into psum SRAM concurrently. It sits directly upstream of `core`, replacing the testbench-driven instruction stream.

## Interface
- `row`, 8: array rows; weight vectors fetched per job.
- `col`, 8: array columns; used for the load-gap default.
- `l0_depth`, 64: maximum activation vectors fetched per chunk. Must not exceed L0 depth.
- `load_gap`, 16: idle cycles after weight load, before the first activation fetch.
- `drain_timeout`, 255: maximum cycles without `ofifo_valid` allowed in DRAIN.

- `clk`  in  1  — single clock, rising edge.
- `reset`  in  1  — asynchronous, active-low reset.
- `start`  in  1  — job request; sampled only in IDLE.
- `w_base`  in  11  — xmem base address of `row` weight vectors.
- `x_base`  in  11  — xmem base address of activation vectors.
- `p_base`  in  11  — pmem base address for results.
- `len`  in  11  — number of activation vectors (0–2047).
- `acc_en`  in  1  — driven onto inst[33] for the whole job.
- `ofifo_valid`  in  1  — from `core`; OFIFO head holds a valid word.
- `inst`  out  34  — registered instruction word to `core`.
- `busy`  out  1  — high from the cycle after start is accepted until done.
- `done`  out  1  — one-cycle pulse at job end.
- `err`  out  1  — drain timeout occurred; sticky until the next accepted start.

## Operation
- Instruction field map:
  - acc 33, CEN_pmem 32, WEN_pmem 31, A_pmem 30:20
  - CEN_xmem 19, WEN_xmem 18, A_xmem 17:7
  - ofifo_rd 6, ififo_wr 5, ififo_rd 4, l0_rd 3, l0_wr 2, execute 1, load 0
  - CEN/WEN are active-low.
- IDLE_INST = 34'h1_800C_0000: both SRAMs disabled, all strobes 0.
- Reset values: `inst` = IDLE_INST; `busy`, `done`, `err` = 0; all counters 0; FSM in IDLE.
- On `start` in IDLE, the descriptor is latched. All later address arithmetic is on latched values, modulo 2048 (11-bit wrap).
- `start` while busy is ignored.
- `len`=0 goes IDLE→FINISH directly: no SRAM access, `done` pulses.
- FSM states:
  - IDLE → W_FETCH: `row` cycles; CEN_xmem=0, WEN_xmem=1, A_xmem=w_base+k.
  - W_FETCH → W_LOAD: `row` cycles; l0_rd=1, load=1.
  - W_LOAD → W_GAP: `load_gap` cycles of idle strobes.
  - W_GAP → X_FETCH: c = min(l0_depth, remaining) cycles; reads x_base+i, with i global across chunks.
  - X_FETCH → EXEC: c cycles; l0_rd=1, execute=1.
  - EXEC → X_FETCH if remaining>0, else DRAIN.
  - DRAIN → FINISH when drained count == `len`, or when the timeout counter reaches `drain_timeout` (this sets `err`).
  - FINISH → IDLE: `done`=1 for one cycle; `busy` deasserts in the same cycle.
- L0 write pipeline: l0_wr is asserted exactly one cycle after each xmem read (SRAM read latency 1). The last l0_wr of a fetch state therefore overlaps the first cycle of the next state.
- Drain unit, active in every non-IDLE state:
  - When `ofifo_valid`=1, assert ofifo_rd=1, CEN_pmem=0, WEN_pmem=0, A_pmem=p_base+dcnt in the same cycle, then increment dcnt.
  - Drain stops once dcnt == `len`.
  - The timeout counter counts only in DRAIN, clears on any drained word, and saturates.
- ififo_wr and ififo_rd are always 0.

## Timing
- `start` sampled at edge N; `busy`=1 and the first W_FETCH `inst` appear after edge N+1.
- All `inst` fields are registered, with no combinational path from inputs to `inst`.
- Drain decision uses `ofifo_valid` sampled at edge t; the corresponding `inst` strobes appear after edge t+1.
- `reset` assertion forces the reset values immediately (asynchronous), including mid-job. Any in-flight l0_wr pending bit is cleared.

## Structure
- Package `core_seq_pkg`:
  - state enum
  - field bit-position constants
  - IDLE_INST
- One sub-module, `core_seq_drain`: dcnt, timeout counter, pmem/ofifo strobe generation.

## Test plan
- Reset: drive `reset`=0 mid-cycle → `inst`=34'h1_800C_0000, `busy`=0, `done`=0, `err`=0 immediately.
- Basic job (w_base=0, x_base=16, p_base=32, len=4, acc_en=1):
  - xmem reads at addresses 0–7 with l0_wr lagging one cycle.
  - 8 load cycles, then 16 gap cycles.
  - Reads 16–19, then 4 execute cycles.
  - 4 `ofifo_valid` pulses → pmem writes 32–35.
  - `done` pulse; inst[33]=1 throughout the job.
- Chunking (len=130) → X_FETCH/EXEC pairs of 64, 64 and 2 cycles; activation addresses continuous.
- Wrap (x_base=2046, len=4) → reads 2046, 2047, 0, 1.
- `len`=0 → `done` pulses within 2 cycles of `start`; CEN_xmem and CEN_pmem never go low.
- Timeout: `ofifo_valid` held at 0 → `err`=1 and `done` pulse 255 cycles after DRAIN entry.
- Control: `start` pulsed during EXEC is ignored; reset asserted in EXEC returns the block to IDLE with IDLE_INST.
